inst_fetch: RTL
===============

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter DEPTH, default 2, instruction buffer entries; power of two and at least 2.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 pc_i  input  32  fetch address from PC stage.
REQ-005 ce_i  input  1  PC stage enable; pc_i is valid when 1.
REQ-006 stall_o  output  1  combinational; 1 means pc_i was not taken this cycle and the PC stage must hold.
REQ-007 flush  input  1  discard all buffered and in-flight fetches.
REQ-008 imem_req  output  1  instruction memory request, registered.
REQ-009 imem_addr  output  32  request address, registered, word aligned.
REQ-010 imem_ack  input  1  one-cycle pulse; imem_rdata is valid for that request.
REQ-011 imem_rdata  input  32  instruction word.
REQ-012 id_valid  output  1  decode entry valid; equals buffer non-empty.
REQ-013 id_ready  input  1  decode accepts the entry.
REQ-014 id_pc  output  32  address of the head entry.
REQ-015 id_inst  output  32  instruction of the head entry.
REQ-016 id_exc  output  1  1 if the head entry is a misaligned-fetch exception.

Function
REQ-017 FSM states: IDLE (no request outstanding), REQ (request outstanding), DROP (outstanding request to be discarded).
REQ-018 At most one memory request is outstanding at any time.
REQ-019 Define avail = DEPTH minus buffer occupancy after this cycle's push and pop.
REQ-020 An issue occurs when ce_i=1, flush=0, pc_i[1:0]=0, avail>0, and either the state is IDLE or the state is REQ with imem_ack=1.
REQ-021 On issue: imem_req=1 and imem_addr=pc_i on the next cycle; the state becomes REQ.
REQ-022 stall_o = ce_i AND NOT (issue OR misaligned-accept).
REQ-023 imem_req and imem_addr stay stable while in REQ until the cycle after imem_ack.
REQ-024 In REQ, on imem_ack: push {imem_addr, imem_rdata, exc=0} into the buffer; with no back-to-back issue, deassert imem_req and go to IDLE.
REQ-025 Misaligned pc_i (pc_i[1:0] != 0) accepted under the same conditions as an issue:
- push {pc_i, 32'h0, exc=1} directly;
- no memory request is made.
- At most one push occurs per cycle; a memory-data push has priority, and the misaligned pc stalls for that cycle.
REQ-026 Pop occurs when id_valid=1 and id_ready=1; the next entry is presented on the next cycle. Push and pop may occur in the same cycle.
REQ-027 Occupancy plus outstanding requests never exceeds DEPTH, so a push is never dropped for lack of space.
REQ-028 Buffer pointers wrap modulo DEPTH.
REQ-029 Flush:
- the buffer is emptied and id_valid=0 on the next cycle;
- no issue occurs in the flush cycle.
REQ-030 Flush in REQ without imem_ack: go to DROP; imem_req is held until the ack.
REQ-031 Flush in REQ with imem_ack in the same cycle: the data is discarded; go to IDLE.
REQ-032 In DROP on imem_ack: push nothing and go to IDLE; a new issue may occur in that same cycle if REQ-020 allows, treating DROP as REQ.
REQ-033 Flush in DROP or IDLE: the state is unchanged apart from the buffer clear.
REQ-034 id_pc, id_inst and id_exc are don't-care when id_valid=0 but must not be X after reset.

Reset
REQ-035 While rst=1, asynchronously: state=IDLE, buffer empty, pointers=0, imem_req=0, imem_addr=0, id_valid=0, id_pc=0, id_inst=0, id_exc=0.
REQ-036 Reset mid-request abandons the request; an imem_ack arriving after reset deasserts in IDLE is ignored.

Verification
REQ-037 Reset release, ce_i=1, pc_i=0x0, memory ack 1 cycle after req with rdata=0x24020005, id_ready=1 -> imem_req/imem_addr=0x0, then id_valid=1 with id_pc=0x0, id_inst=0x24020005, id_exc=0.
REQ-038 Back-to-back fetch of 0x0, 0x4, 0x8, id_ready=0 -> buffer fills to DEPTH=2; stall_o=1 holding pc_i=0x8 with no request; raise id_ready -> 0x0 and 0x4 pop in order, then 0x8 is issued.
REQ-039 pc_i=0x6 -> no imem_req; entry id_pc=0x6, id_inst=0, id_exc=1.
REQ-040 Request to 0x10 outstanding, flush pulse, ack 3 cycles later -> DROP entered; id_valid stays 0; no push; IDLE after the ack.
REQ-041 Flush coincident with ack of 0x20 while buffer holds 1 entry -> buffer empty next cycle; 0x20 data discarded; state IDLE.
REQ-042 rst asserted mid-REQ, asynchronously between clock edges -> imem_req=0 and id_valid=0 immediately; a stale ack after release produces no entry.

Source files
------------

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch stage: single-outstanding memory request plus DEPTH-entry decode buffer
module inst_fetch #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    output logic        stall_o,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_exc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic [31:0]     buf_pc   [DEPTH];
    logic [31:0]     buf_inst [DEPTH];
    logic [DEPTH-1:0] buf_exc;

    logic            pop, ack_push, mis_push, push, issue, accept;
    logic            aligned, slot_free, has_room;
    logic [CW:0]     occ_next;
    logic [31:0]     push_pc, push_inst;

    assign pop       = id_valid & id_ready;
    assign ack_push  = (state == REQ) & imem_ack & ~flush;
    // Room is judged on the occupancy left after this cycle's ack push and pop,
    // so an issued request always has a slot reserved for its data.
    assign occ_next  = {1'b0, count} + (CW+1)'(ack_push) - (CW+1)'(pop);
    assign has_room  = occ_next < (CW+1)'(DEPTH);
    assign slot_free = (state == IDLE) | imem_ack;
    assign aligned   = (pc_i[1:0] == 2'b00);
    assign accept    = ce_i & ~flush & has_room & slot_free;
    assign issue     = accept & aligned;
    assign mis_push  = accept & ~aligned & ~ack_push;
    assign push      = ack_push | mis_push;
    assign stall_o   = ce_i & ~(issue | mis_push);
    assign push_pc   = ack_push ? imem_addr : pc_i;
    assign push_inst = ack_push ? imem_rdata : 32'h0;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (issue) state_nxt = REQ;
            REQ: begin
                if (imem_ack)   state_nxt = issue ? REQ : IDLE;
                else if (flush) state_nxt = DROP;
            end
            DROP: if (imem_ack) state_nxt = issue ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            imem_req  <= 1'b0;
            imem_addr <= 32'h0;
        end else begin
            state    <= state_nxt;
            imem_req <= (state_nxt != IDLE);
            if (issue) imem_addr <= pc_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            buf_exc <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_pc[i]   <= 32'h0;
                buf_inst[i] <= 32'h0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                buf_pc[wr_ptr]   <= push_pc;
                buf_inst[wr_ptr] <= push_inst;
                buf_exc[wr_ptr]  <= ~ack_push;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign id_valid = (count != '0);
    assign id_pc    = buf_pc[rd_ptr];
    assign id_inst  = buf_inst[rd_ptr];
    assign id_exc   = buf_exc[rd_ptr];

endmodule
